// File: rtl/backscatter_symbol_sequencer.sv
// Sequences the backscatter toggle counter for one packet: a counter-clear hold
// delay, then one fixed-length symbol per prefetched upstream bit.
module backscatter_symbol_sequencer #(
  parameter int DELAY_CYCLES  = 32,
  parameter int SYMBOL_CYCLES = 88,
  parameter int NBITS_W       = 12
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [NBITS_W-1:0] num_bits,
  input  logic               bit_valid,
  input  logic               bit_data,
  output logic               bit_ready,
  output logic               busy,
  output logic               done,
  output logic               err_underrun,
  output logic               cnt_clear,
  output logic               cnt_en,
  output logic               phase_flip,
  output logic               symbol_strobe
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    SYMBOL = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [11:0]        DLY_LAST = 12'(DELAY_CYCLES - 1);
  localparam logic [11:0]        SYM_LAST = 12'(SYMBOL_CYCLES - 1);
  localparam logic [NBITS_W-1:0] CNT_ONE  = NBITS_W'(1);

  state_t             state_q, state_d;
  logic [11:0]        timer_q, timer_d;
  logic [NBITS_W-1:0] cnt_q, cnt_d;
  logic [NBITS_W-1:0] num_q, num_d;
  logic               bit_q, bit_d;
  logic               err_q, err_d;

  logic bit_ready_q, bit_ready_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic cnt_clear_q, cnt_clear_d;
  logic cnt_en_q, cnt_en_d;
  logic phase_flip_q, phase_flip_d;
  logic symbol_strobe_q, symbol_strobe_d;

  // Next-state logic; outputs are derived from the next state so they register in step with it
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    bit_d   = bit_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          cnt_d   = '0;
          timer_d = 12'd0;
          if (num_bits != '0) begin
            num_d   = num_bits;
            state_d = DELAY;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      DELAY: begin
        if (timer_q == DLY_LAST) begin
          timer_d = 12'd0;
          if (bit_valid) begin
            bit_d   = bit_data;
            state_d = SYMBOL;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      SYMBOL: begin
        if (timer_q == SYM_LAST) begin
          timer_d = 12'd0;
          cnt_d   = cnt_q + CNT_ONE;
          if (cnt_d == num_q) begin
            state_d = DONE;
          end else if (bit_valid) begin
            // Prefetched bit starts the next symbol with no idle clock
            bit_d = bit_data;
          end else begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q + 12'd1;
        end
      end
      DONE: begin
        timer_d = 12'd0;
        state_d = IDLE;
      end
      default: begin
        timer_d = 12'd0;
        state_d = IDLE;
      end
    endcase

    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
    cnt_en_d        = (state_d == SYMBOL);
    cnt_clear_d     = (state_d != SYMBOL);
    phase_flip_d    = cnt_en_d & bit_d;
    symbol_strobe_d = cnt_en_d && (timer_d == SYM_LAST);
    // Ready on the last delay clock, or on a symbol's last clock when more bits remain
    bit_ready_d     = ((state_d == DELAY) && (timer_d == DLY_LAST)) ||
                      (symbol_strobe_d && ((cnt_d + CNT_ONE) != num_d));
  end

  // State, datapath and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= IDLE;
      timer_q         <= 12'd0;
      cnt_q           <= '0;
      num_q           <= '0;
      bit_q           <= 1'b0;
      err_q           <= 1'b0;
      bit_ready_q     <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      cnt_clear_q     <= 1'b1;
      cnt_en_q        <= 1'b0;
      phase_flip_q    <= 1'b0;
      symbol_strobe_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      timer_q         <= timer_d;
      cnt_q           <= cnt_d;
      num_q           <= num_d;
      bit_q           <= bit_d;
      err_q           <= err_d;
      bit_ready_q     <= bit_ready_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      cnt_clear_q     <= cnt_clear_d;
      cnt_en_q        <= cnt_en_d;
      phase_flip_q    <= phase_flip_d;
      symbol_strobe_q <= symbol_strobe_d;
    end
  end

  assign bit_ready     = bit_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_underrun  = err_q;
  assign cnt_clear     = cnt_clear_q;
  assign cnt_en        = cnt_en_q;
  assign phase_flip    = phase_flip_q;
  assign symbol_strobe = symbol_strobe_q;

endmodule

// File: tb/tb_backscatter_symbol_sequencer.sv
// Bench for backscatter_symbol_sequencer: random packets checked clock by clock
// against a timeline model computed from delay/symbol/bit-count arithmetic.
module tb_backscatter_symbol_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, start1, start2, bit_valid, bit_data;
  logic [11:0] num_bits;
  logic rdy1, busy1, done1, err1, clr1, en1, ph1, st1;
  logic rdy2, busy2, done2, err2, clr2, en2, ph2, st2;
  logic [7:0] obs1, obs2;
  assign obs1 = {rdy1, busy1, done1, err1, clr1, en1, ph1, st1};
  assign obs2 = {rdy2, busy2, done2, err2, clr2, en2, ph2, st2};

  backscatter_symbol_sequencer #(.DELAY_CYCLES(4), .SYMBOL_CYCLES(8), .NBITS_W(12)) u_dut (
    .clock(clock), .reset(reset), .start(start1), .num_bits(num_bits),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(rdy1), .busy(busy1),
    .done(done1), .err_underrun(err1), .cnt_clear(clr1), .cnt_en(en1),
    .phase_flip(ph1), .symbol_strobe(st1));

  backscatter_symbol_sequencer #(.DELAY_CYCLES(1), .SYMBOL_CYCLES(2), .NBITS_W(12)) u_dut_fs (
    .clock(clock), .reset(reset), .start(start2), .num_bits(num_bits),
    .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(rdy2), .busy(busy2),
    .done(done2), .err_underrun(err2), .cnt_clear(clr2), .cnt_en(en2),
    .phase_flip(ph2), .symbol_strobe(st2));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference packet: bits, per-bit availability, and derived end clock
  int   m_n, m_f, m_d, m_s, m_e;
  logic m_data  [4096];
  logic m_valid [4096];

  task automatic plan_packet(input int n, input int fail_at, input int d, input int s);
    m_n = n; m_d = d; m_s = s;
    for (int i = 0; i < n; i++) begin
      m_data[i]  = 1'($urandom);
      m_valid[i] = (i != fail_at);
    end
    m_f = (fail_at >= 0 && fail_at < n) ? fail_at : n;
    m_e = (n == 0) ? 1 : (m_d + m_f * m_s + ((m_f == n) ? 0 : 0) + 1);
  endtask

  // Expected {ready,busy,done,err,clear,en,phase,strobe} at clock t after acceptance
  function automatic logic [7:0] exp_out(input int t);
    int   j, p;
    logic e_end;
    e_end = (m_f < m_n);
    if (m_n == 0) return (t == 1) ? 8'b0110_1000 : 8'b0000_1000;
    if (t == m_e) return {3'b011, e_end, 4'b1000};
    if (t > m_e)  return {3'b000, e_end, 4'b1000};
    if (t <= m_d) return {(t == m_d), 7'b100_1000};
    j = (t - m_d - 1) / m_s;
    p = (t - m_d - 1) % m_s;
    return {((p == m_s - 1) && (j + 1 < m_n)), 5'b10001, m_data[j], (p == m_s - 1)};
  endfunction

  // Drive upstream bit source for the edge that ends clock t; noise elsewhere
  task automatic drive_inputs(input int t);
    int i;
    start1 = 1'b0;
    start2 = 1'b0;
    num_bits = 12'($urandom);
    i = (t - m_d) / m_s;
    if (t >= m_d && ((t - m_d) % m_s) == 0 && i < m_n) begin
      bit_valid = m_valid[i];
      bit_data  = m_data[i];
    end else begin
      bit_valid = 1'($urandom);
      bit_data  = 1'($urandom);
    end
  endtask

  task automatic launch(input logic fs);
    @(negedge clock);
    num_bits = 12'(m_n);
    if (fs) start2 = 1'b1;
    else    start1 = 1'b1;
    bit_valid = 1'($urandom);
    @(posedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b1; start1 = 1'b0; start2 = 1'b0;
    bit_valid = 1'b0; bit_data = 1'b0; num_bits = 12'd0;
    repeat (3) @(negedge clock);
    n_tests++;
    if (obs1 !== 8'b0000_1000) begin
      n_fail++; $display("FAIL reset_dut got=%b want=%b", obs1, 8'b0000_1000);
    end
    n_tests++;
    if (obs2 !== 8'b0000_1000) begin
      n_fail++; $display("FAIL reset_dut_fs got=%b want=%b", obs2, 8'b0000_1000);
    end
    reset = 1'b0;
  endtask

  task automatic test_basic;
    plan_packet(3, -1, 4, 8);
    m_data[0] = 1'b1; m_data[1] = 1'b0; m_data[2] = 1'b1;
    launch(1'b0);
    for (int t = 1; t <= m_e + 1; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL basic t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
    end
  endtask

  task automatic test_underrun;
    plan_packet(3, 1, 4, 8);
    launch(1'b0);
    for (int t = 1; t <= m_e + 1; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL underrun t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
    end
    plan_packet(2, -1, 4, 8);
    launch(1'b0);
    for (int t = 1; t <= m_e + 1; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL err_clear t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
    end
  endtask

  task automatic test_zero_bits;
    plan_packet(0, -1, 4, 8);
    launch(1'b0);
    for (int t = 1; t <= 3; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL zero_bits t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
    end
  endtask

  task automatic test_start_ignored;
    plan_packet(3, -1, 4, 8);
    launch(1'b0);
    for (int t = 1; t <= m_e + 1; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL start_ignored t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
      if (t == 10) begin
        start1   = 1'b1;
        num_bits = 12'd1;
      end
    end
  endtask

  task automatic test_reset_mid;
    plan_packet(3, -1, 4, 8);
    launch(1'b0);
    for (int t = 1; t <= 15; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs1 !== exp_out(t)) begin
        n_fail++; $display("FAIL pre_reset t=%0d got=%b want=%b", t, obs1, exp_out(t));
      end
      drive_inputs(t);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (obs1 !== 8'b0000_1000) begin
        n_fail++; $display("FAIL reset_mid k=%0d got=%b want=%b", k, obs1, 8'b0000_1000);
      end
      @(negedge clock);
    end
    test_basic();
  endtask

  task automatic test_random_packets;
    int n, f;
    for (int k = 0; k < 8; k++) begin
      n = int'($urandom_range(1, 6));
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      plan_packet(n, f, 4, 8);
      launch(1'b0);
      for (int t = 1; t <= m_e + 1; t++) begin
        @(negedge clock);
        n_tests++;
        if (obs1 !== exp_out(t)) begin
          n_fail++; $display("FAIL random k=%0d t=%0d got=%b want=%b", k, t, obs1, exp_out(t));
        end
        drive_inputs(t);
      end
    end
  endtask

  task automatic test_full_scale;
    int strobes;
    strobes = 0;
    plan_packet(4095, -1, 1, 2);
    launch(1'b1);
    for (int t = 1; t <= m_e + 1; t++) begin
      @(negedge clock);
      n_tests++;
      if (obs2 !== exp_out(t)) begin
        n_fail++; $display("FAIL full_scale t=%0d got=%b want=%b", t, obs2, exp_out(t));
      end
      if (st2) strobes++;
      if (t == 8192) begin
        n_tests++;
        if (done2 !== 1'b1) begin
          n_fail++; $display("FAIL full_scale_done got=%b want=1", done2);
        end
      end
      drive_inputs(t);
    end
    n_tests++;
    if (strobes != 4095) begin
      n_fail++; $display("FAIL full_scale_strobes got=%0d want=4095", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_underrun();
    test_zero_bits();
    test_start_ignored();
    test_reset_mid();
    test_random_packets();
    test_full_scale();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
